// File: rtl/risc_toy_dmem.sv
// risc_toy_dmem: word-addressed data memory on the RISC_TOY data port.
// Single-port synchronous RAM with an RD_LAT-deep read pipeline, a
// read-valid strobe and a sticky out-of-range flag.
// Build option: define DMEM_STATS_EN to add saturating RD_CNT / WR_CNT
// request counters.
module risc_toy_dmem #(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        DRVALID,
`ifdef DMEM_STATS_EN
  output logic [15:0] RD_CNT,
  output logic [15:0] WR_CNT,
`endif
  output logic        ADDR_ERR
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << AW;

  // Elaboration-time guards on the configuration.
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("risc_toy_dmem: RD_LAT must be in 1..4");
  end
  if (AW < 1 || AW > 29) begin : g_bad_aw
    $error("risc_toy_dmem: AW must be in 1..29");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Read pipeline: index 1 is the capture stage, RD_LAT drives the outputs.
  logic [DATA_W-1:0] data_p [1:RD_LAT];
  logic              vld_p  [1:RD_LAT];

  logic              in_range;
  logic [AW-1:0]     idx;
  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] rd_word;

  assign in_range = (DADDR[29:AW] == '0);
  assign idx      = DADDR[AW-1:0];
  assign rd_req   = DREQ & ~DRW;
  assign wr_req   = DREQ & DRW;
  // Out-of-range reads return zero but still travel the pipeline normally.
  assign rd_word  = in_range ? mem[idx] : '0;

  // RAM write port; out-of-range writes are dropped. Contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_req && in_range) begin
      mem[idx] <= DWDATA;
    end
  end

  // Read pipeline: capture on the request edge, then shift one stage per
  // cycle. Stage data only loads behind a valid, so the last stage (and
  // DRDATA) holds the most recent read result across idle cycles.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int k = 1; k <= RD_LAT; k++) begin
        vld_p[k]  <= 1'b0;
        data_p[k] <= '0;
      end
    end else begin
      // ---- stage 1: sample RAM at the request edge (read-old semantics) ----
      vld_p[1] <= rd_req;
      if (rd_req) begin
        data_p[1] <= rd_word;
      end
      // ---- stages 2..RD_LAT: delay line ----
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) begin
          data_p[k] <= data_p[k-1];
        end
      end
    end
  end

  assign DRDATA  = data_p[RD_LAT];
  assign DRVALID = vld_p[RD_LAT];

  // Sticky out-of-range flag, set by any request (read or write) outside RAM.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ADDR_ERR <= 1'b0;
    end else if (DREQ && !in_range) begin
      ADDR_ERR <= 1'b1;
    end
  end

`ifdef DMEM_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Accepted-request counters, saturating; out-of-range requests count too.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else begin
      if (rd_req) RD_CNT <= sat_inc16(RD_CNT);
      if (wr_req) WR_CNT <= sat_inc16(WR_CNT);
    end
  end
`endif

endmodule
